// File: rtl/multi_cycle_controller.sv
// Moore sequencer for a shared-memory multi-cycle RV32I datapath; outputs decode from state (branch PCWrite from zero/neg).
// Latency per instruction 2..5 cycles; no backpressure, advances every clock.
module multi_cycle_controller #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         op,
  input  logic [2:0]         func3,
  input  logic [6:0]         func7,
  input  logic               zero,
  input  logic               neg,
  output logic               PCWrite,
  output logic               adrSrc,
  output logic               memWrite,
  output logic               IRWrite,
  output logic [1:0]         resultSrc,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         immSrc,
  output logic               regWrite,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECR    = STATE_W'(6),
    S_EXECI    = STATE_W'(7),
    S_ALUWB    = STATE_W'(8),
    S_BRANCH   = STATE_W'(9),
    S_JAL      = STATE_W'(10),
    S_JALR     = STATE_W'(11),
    S_LUI      = STATE_W'(12)
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  state_t     r_state;
  state_t     w_dec_state;
  logic       w_pcw, w_adr, w_mw, w_irw, w_rw, w_taken;
  logic [2:0] w_funct_alu;
  logic       w_unused_func7;

  assign w_unused_func7 = ^{func7[6], func7[4:0]};
  assign state          = r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_LOAD, OP_STORE: r_state <= S_MEMADR;
            OP_R:              r_state <= S_EXECR;
            OP_I:              r_state <= S_EXECI;
            OP_BR:             r_state <= S_BRANCH;
            OP_JAL:            r_state <= S_JAL;
            OP_JALR:           r_state <= S_JALR;
            OP_LUI:            r_state <= S_LUI;
            default:           r_state <= S_FETCH;
          endcase
        end
        S_MEMADR:  r_state <= (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD: r_state <= S_MEMWB;
        S_EXECR:   r_state <= S_ALUWB;
        S_EXECI:   r_state <= S_ALUWB;
        S_JAL:     r_state <= S_ALUWB;
        S_JALR:    r_state <= S_JAL;
        default:   r_state <= S_FETCH;
      endcase
    end
  end

  // I-type func3=000 never subtracts; only R-type honours func7[5]
  always_comb begin
    case (func3)
      3'b000:  w_funct_alu = ((op == OP_R) && func7[5]) ? 3'b001 : 3'b000;
      3'b010:  w_funct_alu = 3'b100;
      3'b100:  w_funct_alu = 3'b101;
      3'b110:  w_funct_alu = 3'b011;
      3'b111:  w_funct_alu = 3'b010;
      default: w_funct_alu = 3'b000;
    endcase
  end

  always_comb begin
    case (func3)
      3'b000:  w_taken = zero;
      3'b001:  w_taken = ~zero;
      3'b100:  w_taken = neg;
      3'b101:  w_taken = ~neg;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    case (op)
      OP_STORE: immSrc = 3'b001;
      OP_BR:    immSrc = 3'b010;
      OP_JAL:   immSrc = 3'b011;
      OP_LUI:   immSrc = 3'b100;
      default:  immSrc = 3'b000;
    endcase
  end

  assign w_dec_state = rst ? S_FETCH : r_state;

  always_comb begin
    w_pcw      = 1'b0;
    w_adr      = 1'b0;
    w_mw       = 1'b0;
    w_irw      = 1'b0;
    w_rw       = 1'b0;
    resultSrc  = 2'b00;
    ALUControl = 3'b000;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    case (w_dec_state)
      S_FETCH: begin
        w_irw = 1'b1; w_pcw = 1'b1; ALUSrcB = 2'b10; resultSrc = 2'b10;
      end
      S_DECODE:   begin ALUSrcA = 2'b01; ALUSrcB = 2'b01; end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  w_adr = 1'b1;
      S_MEMWB:    begin resultSrc = 2'b01; w_rw = 1'b1; end
      S_MEMWRITE: begin w_adr = 1'b1; w_mw = 1'b1; end
      S_EXECR:    begin ALUSrcA = 2'b10; ALUControl = w_funct_alu; end
      S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; ALUControl = w_funct_alu; end
      S_ALUWB:    w_rw = 1'b1;
      S_BRANCH:   begin ALUSrcA = 2'b10; ALUControl = 3'b001; w_pcw = w_taken; end
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; w_pcw = 1'b1; end
      S_JALR:     begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_LUI:      begin resultSrc = 2'b11; w_rw = 1'b1; end
      default: ;
    endcase
  end

  assign PCWrite  = w_pcw & ~rst;
  assign adrSrc   = w_adr;
  assign memWrite = w_mw & ~rst;
  assign IRWrite  = w_irw & ~rst;
  assign regWrite = w_rw & ~rst;

endmodule
